// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO station-management master.
// Generates MDC from clk, shifts out a 32-bit preamble plus the 32-bit frame
// word MSB first, and for read frames releases the line at turnaround and
// captures 16 data bits from mdio_in.
module mdio_master #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_start,
  input  logic [31:0] t_data,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        busy,
  output logic        mdio_done,
  output logic [15:0] rd_data
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_FRAME = 3'd2;
  localparam logic [2:0] ST_TA    = 3'd3;
  localparam logic [2:0] ST_RD    = 3'd4;

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [5:0] BIT_FRAME = 6'd32;
  localparam logic [5:0] BIT_TA    = 6'd46;
  localparam logic [5:0] BIT_RD    = 6'd48;
  localparam logic [5:0] BIT_LAST  = 6'd63;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       bit_q, bit_d;
  logic             mdc_q, mdc_d;
  logic             out_q, out_d;
  logic             oe_q, oe_d;
  logic             done_q, done_d;
  logic [15:0]      rd_q, rd_d;
  logic [31:0]      frame_q, frame_d;
  logic [15:0]      shift_q, shift_d;

  logic             is_rd;
  logic [5:0]       bit_nx;

  // OP == 10 is the only read opcode; everything else is sent as a write.
  assign is_rd  = (frame_q[29:28] == 2'b10);
  assign bit_nx = bit_q + 6'd1;

  function automatic logic [2:0] state_for_bit(input logic [5:0] b, input logic rd);
    if (b < BIT_FRAME)      return ST_PRE;
    if (rd && (b >= BIT_RD)) return ST_RD;
    if (rd && (b >= BIT_TA)) return ST_TA;
    return ST_FRAME;
  endfunction

  // Bits 32..63 map to frame[63-b], which for b in 32..63 is frame[~b[4:0]].
  function automatic logic drive_for_bit(input logic [5:0] b, input logic rd,
                                         input logic [31:0] f);
    if (b < BIT_FRAME)       return 1'b1;
    if (rd && (b >= BIT_TA)) return 1'b0;
    return f[~b[4:0]];
  endfunction

  function automatic logic oe_for_bit(input logic [5:0] b, input logic rd);
    return !(rd && (b >= BIT_TA));
  endfunction

  // Next-state logic: divider, bit counter, line drive and read capture.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    mdc_d   = mdc_q;
    out_d   = out_q;
    oe_d    = oe_q;
    done_d  = 1'b0;
    rd_d    = rd_q;
    frame_d = frame_q;
    shift_d = shift_q;

    if (state_q == ST_IDLE) begin
      mdc_d = 1'b0;
      if (mdio_start) begin
        frame_d = t_data;
        state_d = ST_PRE;
        div_d   = '0;
        bit_d   = '0;
        out_d   = 1'b1;
        oe_d    = 1'b1;
      end
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      if (!mdc_q) begin
        // Rising MDC: the PHY side has held mdio_in for the whole low phase.
        mdc_d = 1'b1;
        if (state_q == ST_RD) begin
          shift_d = {shift_q[14:0], mdio_in};
        end
      end else begin
        // Falling MDC is the bit boundary; drive only changes here.
        mdc_d = 1'b0;
        if (bit_q == BIT_LAST) begin
          state_d = ST_IDLE;
          out_d   = 1'b0;
          oe_d    = 1'b0;
          done_d  = 1'b1;
          if (is_rd) begin
            rd_d = shift_q;
          end
        end else begin
          bit_d   = bit_nx;
          state_d = state_for_bit(bit_nx, is_rd);
          out_d   = drive_for_bit(bit_nx, is_rd, frame_q);
          oe_d    = oe_for_bit(bit_nx, is_rd);
        end
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Control and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      mdc_q   <= 1'b0;
      out_q   <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      mdc_q   <= mdc_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
    end
  end

  // Frame word and read shift register carry data only, no reset needed.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
    shift_q <= shift_d;
  end

  assign mdc       = mdc_q;
  assign mdio_out  = out_q;
  assign mdio_oe   = oe_q;
  assign busy      = (state_q != ST_IDLE);
  assign mdio_done = done_q;
  assign rd_data   = rd_q;

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed bench for mdio_master with a CLK_DIV=2 and a
// CLK_DIV=1 instance, a PHY-side read-data model and an MDC-rise monitor.
module tb_mdio_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start0, start1, sel;
  logic [31:0] t_data;
  logic        phy_in;

  logic        mdc0, out0, oe0, busy0, done0;
  logic [15:0] rd0;
  logic        mdc1, out1, oe1, busy1, done1;
  logic [15:0] rd1;

  logic        m_mdc, m_out, m_oe, m_busy, m_done;
  logic [15:0] m_rd;

  assign m_mdc  = sel ? mdc1  : mdc0;
  assign m_out  = sel ? out1  : out0;
  assign m_oe   = sel ? oe1   : oe0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_rd   = sel ? rd1   : rd0;

  mdio_master #(.CLK_DIV(2)) u_dut0 (
    .clk(clk), .reset(reset), .mdio_start(start0), .t_data(t_data),
    .mdio_in(phy_in), .mdc(mdc0), .mdio_out(out0), .mdio_oe(oe0),
    .busy(busy0), .mdio_done(done0), .rd_data(rd0)
  );

  mdio_master #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .mdio_start(start1), .t_data(t_data),
    .mdio_in(phy_in), .mdc(mdc1), .mdio_out(out1), .mdio_oe(oe1),
    .busy(busy1), .mdio_done(done1), .rd_data(rd1)
  );

  // PHY model: tracks the bit index from MDC falls and drives read data.
  int          phy_bit  = 99;
  logic [15:0] phy_word = 16'h0000;
  always @(negedge m_mdc or posedge m_busy or negedge m_busy) begin
    if (m_busy !== 1'b1)  phy_bit = 99;
    else if (phy_bit == 99) phy_bit = 0;
    else                  phy_bit = phy_bit + 1;
  end
  assign phy_in = (phy_bit >= 48 && phy_bit <= 63) ? phy_word[4'(63 - phy_bit)] : 1'b0;

  // Monitor: capture line state at each MDC rise, snapshot at each done.
  int          cyc = 0, rise_n = 0, done_n = 0, first_cyc = 0;
  logic        mdc_prev = 1'b0, busy_prev = 1'b0;
  logic [15:0] rd_prev = 16'h0000;
  logic [63:0] cap_out = '0, cap_oe = '0;
  logic [63:0] snap_out [8];
  logic [63:0] snap_oe  [8];
  int          snap_rise [8], snap_lat [8], snap_first [8], snap_end [8];
  logic [15:0] snap_rd [8], snap_rd_pre [8];

  always @(negedge clk) begin
    logic [2:0] k;
    cyc = cyc + 1;
    if (m_busy === 1'b1 && busy_prev !== 1'b1) begin
      rise_n = 0; cap_out = '0; cap_oe = '0; first_cyc = cyc;
    end
    if (m_mdc === 1'b1 && mdc_prev !== 1'b1) begin
      if (rise_n < 64) begin
        cap_out[6'(63 - rise_n)] = m_out;
        cap_oe[6'(63 - rise_n)]  = m_oe;
      end
      rise_n = rise_n + 1;
    end
    if (m_done === 1'b1) begin
      k = 3'(done_n);
      snap_out[k]    = cap_out;
      snap_oe[k]     = cap_oe;
      snap_rise[k]   = rise_n;
      snap_lat[k]    = cyc - first_cyc;
      snap_first[k]  = first_cyc;
      snap_end[k]    = cyc;
      snap_rd[k]     = m_rd;
      snap_rd_pre[k] = rd_prev;
      done_n = done_n + 1;
    end
    mdc_prev  = m_mdc;
    busy_prev = m_busy;
    rd_prev   = m_rd;
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_frame(input logic s, input logic [31:0] d);
    t_data = d;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int d0 = done_n;
    int k  = 0;
    while (done_n < d0 + n && k < budget) begin
      tick();
      k = k + 1;
    end
    check("frame_done", 64'(done_n - d0), 64'(n));
  endtask

  localparam logic [31:0] WR_WORD = 32'h5096ABCD;
  localparam logic [31:0] RD_WORD = 32'h61200000;
  localparam logic [63:0] WR_OUT  = {32'hFFFFFFFF, 32'h5096ABCD};
  localparam logic [63:0] RD_OUT  = {32'hFFFFFFFF, 32'h61200000};
  localparam logic [63:0] WR_OE   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] RD_OE   = 64'hFFFF_FFFF_FFFC_0000;

  initial begin
    logic [2:0] f;
    int         d0, k;

    reset = 1'b0; start0 = 1'b1; start1 = 1'b0; sel = 1'b0; t_data = WR_WORD;

    // Reset held with start asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_outs", 64'({m_mdc, m_out, m_oe, m_busy, m_done}), 64'(5'b00000));
      check("rst_rd", 64'(m_rd), 64'(16'h0000));
    end
    reset = 1'b1; start0 = 1'b0;
    tick(); tick();
    check("idle_outs", 64'({m_mdc, m_out, m_oe, m_busy, m_done}), 64'(5'b00000));

    // Write frame at CLK_DIV=2
    f = 3'(done_n);
    start_frame(1'b0, WR_WORD);
    check("start_state", 64'({m_busy, m_oe, m_out, m_mdc}), 64'(4'b1110));
    wait_done(1, 400);
    check("wr_done_single", 64'(m_done), 64'(1'b0));
    check("wr_out", snap_out[f], WR_OUT);
    check("wr_oe", snap_oe[f], WR_OE);
    check("wr_rises", 64'(snap_rise[f]), 64'(64));
    check("wr_latency", 64'(snap_lat[f]), 64'(256));
    check("wr_rd_kept", 64'(snap_rd[f]), 64'(16'h0000));
    d0 = done_n;
    repeat (10) tick();
    check("wr_no_extra_done", 64'(done_n - d0), 64'(0));

    // Read frame, PHY returns FEED
    phy_word = 16'hFEED;
    f = 3'(done_n);
    start_frame(1'b0, RD_WORD);
    wait_done(1, 400);
    check("rd_out", snap_out[f], RD_OUT);
    check("rd_oe", snap_oe[f], RD_OE);
    check("rd_data_at_done", 64'(snap_rd[f]), 64'(16'hFEED));
    check("rd_data_before_done", 64'(snap_rd_pre[f]), 64'(16'h0000));
    check("rd_latency", 64'(snap_lat[f]), 64'(256));
    f = 3'(done_n);
    start_frame(1'b0, WR_WORD);
    wait_done(1, 400);
    check("wr_after_rd_keeps", 64'(snap_rd[f]), 64'(16'hFEED));

    // Busy rejection: start with all-ones word in bit 40
    tick();
    f  = 3'(done_n);
    d0 = done_n;
    start_frame(1'b0, WR_WORD);
    k = 0;
    while (rise_n < 41 && k < 400) begin tick(); k = k + 1; end
    check("busy_at_bit40", 64'(m_busy), 64'(1'b1));
    start_frame(1'b0, 32'hFFFFFFFF);
    wait_done(1, 400);
    check("busy_rej_out", snap_out[f], WR_OUT);
    repeat (300) tick();
    check("busy_rej_one_done", 64'(done_n - d0), 64'(1));
    check("busy_rej_idle", 64'(m_busy), 64'(1'b0));

    // Abort a read at bit 20
    d0 = done_n;
    start_frame(1'b0, RD_WORD);
    k = 0;
    while (rise_n < 21 && k < 400) begin tick(); k = k + 1; end
    reset = 1'b0;
    tick();
    check("abort_outs", 64'({m_mdc, m_out, m_oe, m_busy, m_done}), 64'(5'b00000));
    check("abort_rd", 64'(m_rd), 64'(16'h0000));
    reset = 1'b1;
    repeat (300) tick();
    check("abort_no_done", 64'(done_n - d0), 64'(0));
    f = 3'(done_n);
    start_frame(1'b0, WR_WORD);
    wait_done(1, 400);
    check("post_abort_out", snap_out[f], WR_OUT);
    check("post_abort_rises", 64'(snap_rise[f]), 64'(64));

    // CLK_DIV=1 back-to-back write then read
    sel = 1'b1;
    phy_word = 16'hCAFE;
    tick();
    f = 3'(done_n);
    start_frame(1'b1, WR_WORD);
    k = 0;
    while (m_done !== 1'b1 && k < 300) begin tick(); k = k + 1; end
    check("b2b_first_done", 64'(m_done), 64'(1'b1));
    t_data = RD_WORD;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("b2b_second_busy", 64'(m_busy), 64'(1'b1));
    wait_done(1, 300);
    check("b2b_wr_out", snap_out[f], WR_OUT);
    check("b2b_wr_latency", 64'(snap_lat[f]), 64'(128));
    check("b2b_rd_latency", 64'(snap_lat[3'(f + 3'd1)]), 64'(128));
    check("b2b_gap", 64'(snap_first[3'(f + 3'd1)]), 64'(snap_end[f] + 1));
    check("b2b_rd_out", snap_out[3'(f + 3'd1)], RD_OUT);
    check("b2b_rd_oe", snap_oe[3'(f + 3'd1)], RD_OE);
    check("b2b_rd_data", 64'(snap_rd[3'(f + 3'd1)]), 64'(16'hCAFE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Clause-22 MDIO station-management master. It sits directly upstream of the PHY-side MDIO controller and drives that controller's mdio_out and mdio_oe inputs.
- On mdio_start it latches a 32-bit frame word and generates MDC from the system clock.
- It serializes a 32-bit all-ones preamble followed by the frame, MSB first.
- For read operations it releases the line at turnaround and captures 16 data bits from mdio_in.

Parameters:
CLK_DIV, 2, MDC half-period in clk cycles; legal range >= 1. One MDC bit period = 2*CLK_DIV clk cycles.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
mdio_start  input  1  one-cycle request; sampled only while busy=0
t_data  input  32  frame word: [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] DATA
mdio_in  input  1  serial data from PHY-side controller, valid during read data bits
mdc  output  1  management clock
mdio_out  output  1  serial data to PHY-side controller
mdio_oe  output  1  1 = master drives mdio_out
busy  output  1  frame in progress
mdio_done  output  1  one-cycle pulse at frame end
rd_data  output  16  last captured read data

Behaviour:
- Reset (reset=0 at a clk edge):
  - mdc=0, mdio_out=0, mdio_oe=0, busy=0, mdio_done=0, rd_data=16'h0000.
  - Internal counters cleared; state=IDLE.
  - Reset mid-frame aborts immediately. No mdio_done is produced and the latched frame is discarded.
- States: IDLE, PREAMBLE (bits 0..31), FRAME (bits 32..63 with oe=1), TURNAROUND (read only, bits 46..47, oe=0), READ_DATA (read only, bits 48..63, oe=0).
- Read detect: latched OP == 2'b10. Every other OP value (00, 01, 11) is sent as a write, with oe=1 for all 64 bits. ST, TA and addresses are transmitted unchanged, with no validation.
- Start:
  - In IDLE, mdio_start=1 at edge N latches t_data.
  - At edge N+1: busy=1, mdio_oe=1, mdio_out=1 (preamble bit 0), mdc=0.
  - mdio_start while busy=1 is ignored and t_data is not re-latched.
- MDC:
  - A divider counts 0..CLK_DIV-1. mdc toggles when the count wraps.
  - mdc is low for the first CLK_DIV cycles of each bit and high for the second CLK_DIV cycles.
  - mdc is held 0 in IDLE.
- Drive:
  - mdio_out and mdio_oe update only on bit boundaries, i.e. with the mdc 1->0 transition and on the first bit.
  - Both are therefore stable across every mdc rising edge.
- Bit map (64-bit counter index b):
  - b 0..31: mdio_out=1.
  - b 32..63: mdio_out = latched t_data[63-b].
- Read turnaround and data:
  - From bit 46 onward: mdio_oe=0 and mdio_out=0.
  - During bits 48..63, mdio_in is sampled on the clk edge where mdc goes 0->1 and shifted into a shift register MSB first.
  - Bits 46..47 (TA) are not sampled.
- End of frame:
  - On the clk edge that ends bit 63 (where mdc would go 1->0): mdc=0, mdio_oe=0, mdio_out=0, busy=0, mdio_done=1 for exactly one cycle, state=IDLE.
  - For reads, rd_data loads the shift register on the same edge.
  - rd_data is held until the next completed read; writes and aborted frames leave it unchanged.
- Latency: frame length = 64*2*CLK_DIV clk cycles from first drive to mdio_done (256 at default).
- Back-to-back: a start asserted in the mdio_done cycle is accepted, because busy=0 in that cycle. The next frame begins on the following edge.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with mdio_start=1 -> all outputs 0, busy stays 0. After release, idle outputs remain 0 with mdio_start=0.
2. Write: t_data=32'h5096ABCD (OP=01, PHYAD=1, REGAD=5, DATA=ABCD) at CLK_DIV=2 -> sampling mdio_out on mdc rises yields 32 ones then 5096ABCD MSB first. mdio_oe=1 for all 64 bits. mdio_done is a single pulse 256 cycles after first drive. rd_data stays 0000.
3. Read: t_data=32'h61200000 (OP=10, PHYAD=2, REGAD=8); bench PHY model drives 16'hFEED on mdio_in during bits 48..63 -> mdio_oe falls at bit 46. rd_data=16'hFEED coincident with the mdio_done pulse. A following write leaves FEED intact.
4. Busy rejection: during frame 2, pulse mdio_start with t_data=32'hFFFFFFFF at bit 40 -> serialized bits unchanged. Exactly one mdio_done, and no second frame starts.
5. Abort: reset=0 for one cycle at bit 20 of a read -> outputs return to reset values, no mdio_done, rd_data=0000. A new start then produces a full 32-bit preamble.
6. CLK_DIV=1, back-to-back write then read, with the second start asserted in the mdio_done cycle -> mdc period 2 clk, each frame 128 cycles, second frame's preamble begins the next cycle. Read returns the driven 16'hCAFE.
